// File: rtl/ysyx_23060184_mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
// The arbiter FSM states and the one-hot grant encodings are declared here.
package ysyx_23060184_mem_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_t;

  // Grant is one-hot {lsu, ifu}; all-zero means no owner.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IFU  = 2'b01;
  localparam logic [1:0] GNT_LSU  = 2'b10;

endpackage

// File: rtl/ysyx_23060184_mem_arbiter_pick.sv
// Combinational 2-way picker: req[1] = LSU, req[0] = IFU, returns a one-hot pick.
// YSYX_23060184_ARB_RR_EN selects round-robin on ties (last_owner: 1 = LSU last);
// otherwise LSU always beats IFU and last_owner is ignored.
module ysyx_23060184_arb_pick
  import ysyx_23060184_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] pick
);

`ifdef YSYX_23060184_ARB_RR_EN
  // On a tie, hand the port to whoever did not own the last completed transaction.
  always_comb begin
    pick = GNT_NONE;
    if (req == 2'b11) pick = last_owner ? GNT_IFU : GNT_LSU;
    else              pick = req;
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  // Fixed priority: LSU first, IFU only when LSU is not asking.
  always_comb begin
    pick = GNT_NONE;
    if (req[1])      pick = GNT_LSU;
    else if (req[0]) pick = GNT_IFU;
  end
`endif

endmodule

// File: rtl/ysyx_23060184_mem_arbiter.sv
// Shares one memory port between the IFU (read-only) and the LSU, one transaction
// at a time: arbitrate (IDLE) -> issue request (ISSUE) -> wait for response (RESP).
// Optional feature macro: YSYX_23060184_ARB_RR_EN enables round-robin tie breaking.
module ysyx_23060184_mem_arbiter
  import ysyx_23060184_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    ifu_req_valid,
  output logic                    ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr,
  output logic                    ifu_resp_valid,
  input  logic                    ifu_resp_ready,
  output logic [DATA_WIDTH-1:0]   ifu_rdata,
  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr,
  input  logic                    lsu_wen,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
  output logic                    lsu_resp_valid,
  input  logic                    lsu_resp_ready,
  output logic [DATA_WIDTH-1:0]   lsu_rdata,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wen,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_resp_valid,
  output logic                    mem_resp_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [1:0]              grant
);

  arb_state_t state;
  logic [1:0] pick;
  logic       last_owner;
  logic       owner_lsu;
  logic       owner_req_valid;
  logic       owner_resp_ready;
  logic       in_issue;
  logic       in_resp;

`ifndef YSYX_23060184_ARB_RR_EN
  assign last_owner = 1'b0;
`endif

  ysyx_23060184_arb_pick u_pick (
    .req        ({lsu_req_valid, ifu_req_valid}),
    .last_owner (last_owner),
    .pick       (pick)
  );

  assign owner_lsu        = grant[1];
  assign owner_req_valid  = owner_lsu ? lsu_req_valid  : ifu_req_valid;
  assign owner_resp_ready = owner_lsu ? lsu_resp_ready : ifu_resp_ready;

  // Handshake outputs are gated by rstn so a response in flight during reset is dropped.
  assign in_issue = rstn && (state == ARB_ISSUE);
  assign in_resp  = rstn && (state == ARB_RESP);

  // Arbiter FSM with registered grant; every transaction returns to IDLE (1-cycle bubble).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ARB_IDLE;
      grant <= GNT_NONE;
`ifdef YSYX_23060184_ARB_RR_EN
      last_owner <= 1'b0;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (ifu_req_valid || lsu_req_valid) begin
            state <= ARB_ISSUE;
            grant <= pick;
          end
        end
        ARB_ISSUE: begin
          if (mem_req_valid && mem_req_ready) begin
            state <= ARB_RESP;
          end else if (!owner_req_valid) begin
            // Owner withdrew before the memory took the request: abort, no access.
            state <= ARB_IDLE;
            grant <= GNT_NONE;
          end
        end
        ARB_RESP: begin
          if (mem_resp_valid && mem_resp_ready) begin
            state <= ARB_IDLE;
            grant <= GNT_NONE;
`ifdef YSYX_23060184_ARB_RR_EN
            last_owner <= owner_lsu;
`endif
          end
        end
        default: begin
          state <= ARB_IDLE;
          grant <= GNT_NONE;
        end
      endcase
    end
  end

  // Request-side routing: the owner's payload goes to memory, memory's ready goes to the owner.
  always_comb begin
    mem_req_valid = in_issue && owner_req_valid;
    ifu_req_ready = in_issue && grant[0] && mem_req_ready;
    lsu_req_ready = in_issue && grant[1] && mem_req_ready;
    mem_addr      = owner_lsu ? lsu_addr : ifu_addr;
    mem_wen       = owner_lsu && lsu_wen;
    mem_wdata     = owner_lsu ? lsu_wdata : '0;
    mem_wmask     = owner_lsu ? lsu_wmask : '0;
  end

  // Response-side routing: only the owner sees the response while in RESP.
  always_comb begin
    mem_resp_ready = in_resp && owner_resp_ready;
    ifu_resp_valid = in_resp && grant[0] && mem_resp_valid;
    lsu_resp_valid = in_resp && grant[1] && mem_resp_valid;
    ifu_rdata      = mem_rdata;
    lsu_rdata      = mem_rdata;
  end

endmodule

// File: tb/tb_ysyx_23060184_mem_arbiter.sv
// Self-checking bench for ysyx_23060184_mem_arbiter. The bench plays both requesters
// and the memory; a transaction-level model predicts the winner of every arbitration.
module tb_ysyx_23060184_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ifu_req_valid = 1'b0;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr = '0;
  logic        ifu_resp_valid;
  logic        ifu_resp_ready = 1'b0;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid = 1'b0;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr = '0;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic        lsu_resp_valid;
  logic        lsu_resp_ready = 1'b0;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0;
  logic        mem_resp_ready;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  grant;

  int errors = 0;
  int checks = 0;
  bit model_last = 1'b0;  // 1 = LSU completed the most recent transaction

  always #5 clk = ~clk;

  ysyx_23060184_mem_arbiter dut (
    .clk(clk), .rstn(rstn),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata),
    .grant(grant)
  );

  // Reference arbitration rule: returns 1 when the LSU should win.
  function automatic bit model_winner(input bit i_req, input bit l_req);
    if (l_req && !i_req) return 1'b1;
    if (i_req && !l_req) return 1'b0;
`ifdef YSYX_23060184_ARB_RR_EN
    return !model_last;
`else
    return 1'b1;
`endif
  endfunction

  // Serves one transaction end to end, starting at a negedge where arbitration is due next.
  task automatic serve(input bit exp_lsu, input int req_wait, input int resp_wait, input int rdy_wait);
    logic [1:0]  exp_gnt;
    logic [31:0] exp_addr, exp_wdata, rd, o_rdata;
    logic        exp_wen;
    logic [3:0]  exp_mask;
    int t;
    exp_gnt   = exp_lsu ? 2'b10 : 2'b01;
    exp_addr  = exp_lsu ? lsu_addr : ifu_addr;
    exp_wen   = exp_lsu ? lsu_wen : 1'b0;
    exp_wdata = lsu_wdata;
    exp_mask  = exp_lsu ? lsu_wmask : 4'h0;
    mem_req_ready = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (grant === 2'b00 && t < 8);
    checks++; if (t != 1) begin errors++; $display("FAIL arb_latency: got %0d cycles want 1", t); end
    checks++; if (grant !== exp_gnt) begin errors++; $display("FAIL grant: got %b want %b", grant, exp_gnt); end
    for (int i = 0; i < req_wait; i++) begin
      checks++;
      if (mem_req_valid !== 1'b1 || ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0 || mem_addr !== exp_addr || grant !== exp_gnt) begin
        errors++; $display("FAIL issue_hold: valid=%b rdy=%b%b addr=%h gnt=%b want 1 00 %h %b",
                            mem_req_valid, lsu_req_ready, ifu_req_ready, mem_addr, grant, exp_addr, exp_gnt);
      end
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b1 || (exp_lsu ? lsu_req_ready : ifu_req_ready) !== 1'b1 ||
        (exp_lsu ? ifu_req_ready : lsu_req_ready) !== 1'b0) begin
      errors++; $display("FAIL req_handshake: valid=%b lsu_rdy=%b ifu_rdy=%b owner_lsu=%b",
                          mem_req_valid, lsu_req_ready, ifu_req_ready, exp_lsu);
    end
    checks++;
    if (mem_addr !== exp_addr || mem_wen !== exp_wen || mem_wmask !== exp_mask || (exp_lsu && mem_wdata !== exp_wdata)) begin
      errors++; $display("FAIL payload: got %h/%b/%h/%h want %h/%b/%h/%h",
                          mem_addr, mem_wen, mem_wdata, mem_wmask, exp_addr, exp_wen, exp_wdata, exp_mask);
    end
    @(negedge clk);
    mem_req_ready = 1'b0;
    if (exp_lsu) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b0 || grant !== exp_gnt) begin
      errors++; $display("FAIL resp_entry: mem_req_valid=%b grant=%b want 0 %b", mem_req_valid, grant, exp_gnt);
    end
    for (int i = 0; i < resp_wait; i++) begin
      checks++; if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin
        errors++; $display("FAIL resp_idle: resp_valid=%b%b want 00", lsu_resp_valid, ifu_resp_valid);
      end
      @(negedge clk); #1;
    end
    rd = $urandom;
    mem_rdata = rd;
    mem_resp_valid = 1'b1;
    for (int i = 0; i < rdy_wait; i++) begin
      #1;
      checks++;
      if ((exp_lsu ? lsu_resp_valid : ifu_resp_valid) !== 1'b1 || (exp_lsu ? ifu_resp_valid : lsu_resp_valid) !== 1'b0 ||
          mem_resp_ready !== 1'b0) begin
        errors++; $display("FAIL resp_stall: resp_valid=%b%b mem_resp_ready=%b owner_lsu=%b",
                            lsu_resp_valid, ifu_resp_valid, mem_resp_ready, exp_lsu);
      end
      @(negedge clk);
    end
    if (exp_lsu) lsu_resp_ready = 1'b1; else ifu_resp_ready = 1'b1;
    #1;
    o_rdata = exp_lsu ? lsu_rdata : ifu_rdata;
    checks++;
    if ((exp_lsu ? lsu_resp_valid : ifu_resp_valid) !== 1'b1 || mem_resp_ready !== 1'b1 || o_rdata !== rd) begin
      errors++; $display("FAIL resp_handshake: resp_valid=%b%b mem_resp_ready=%b rdata=%h want rdata %h",
                          lsu_resp_valid, ifu_resp_valid, mem_resp_ready, o_rdata, rd);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    lsu_resp_ready = 1'b0;
    ifu_resp_ready = 1'b0;
    #1;
    checks++; if (grant !== 2'b00 || ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin
      errors++; $display("FAIL release: grant=%b resp_valid=%b%b want 00 00", grant, lsu_resp_valid, ifu_resp_valid);
    end
    model_last = exp_lsu;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
    checks++;
    if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_resp_ready} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 000000",
                          {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_resp_ready});
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    rstn = 1'b1;
    model_last = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_ifu();
    ifu_addr = 32'h8000_0000;
    ifu_req_valid = 1'b1;
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b1;  // early response must be ignored outside RESP
    mem_rdata = 32'h0000_0413;
    ifu_resp_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (grant !== 2'b01 || mem_req_valid !== 1'b1 || ifu_req_ready !== 1'b1 || mem_addr !== 32'h8000_0000 ||
        mem_wen !== 1'b0 || mem_wmask !== 4'h0) begin
      errors++; $display("FAIL ifu_issue: grant=%b valid=%b rdy=%b addr=%h wen=%b mask=%h", grant, mem_req_valid,
                          ifu_req_ready, mem_addr, mem_wen, mem_wmask);
    end
    checks++; if (ifu_resp_valid !== 1'b0 || mem_resp_ready !== 1'b0) begin
      errors++; $display("FAIL early_resp_ignored: resp_valid=%b mem_resp_ready=%b want 0 0", ifu_resp_valid, mem_resp_ready);
    end
    @(negedge clk);
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b0;
    #1;
    checks++; if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h0000_0413 || mem_resp_ready !== 1'b1) begin
      errors++; $display("FAIL ifu_resp: valid=%b rdata=%h ready=%b want 1 00000413 1", ifu_resp_valid, ifu_rdata, mem_resp_ready);
    end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b00 || ifu_resp_valid !== 1'b0) begin
      errors++; $display("FAIL ifu_release: grant=%b resp_valid=%b want 00 0", grant, ifu_resp_valid);
    end
    mem_resp_valid = 1'b0;
    ifu_resp_ready = 1'b0;
    model_last = 1'b0;
  endtask

  task automatic test_collision();
    bit first;
    ifu_addr = 32'h8000_0004;
    ifu_req_valid = 1'b1;
    lsu_addr = 32'h8000_1000;
    lsu_wen = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF;
    lsu_wmask = 4'hF;
    lsu_req_valid = 1'b1;
    first = model_winner(1'b1, 1'b1);
    checks++; if (first !== 1'b1) begin errors++; $display("FAIL collision_model: got %b want 1", first); end
    serve(first, 1, 1, 0);
    serve(!first, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    lsu_addr = 32'h8000_2000;
    lsu_wen = 1'b0;
    lsu_wdata = $urandom;
    lsu_wmask = 4'h0;
    lsu_req_valid = 1'b1;
    serve(1'b1, 5, 0, 3);
  endtask

  task automatic test_abort_reset();
    lsu_addr = 32'h8000_3000;
    lsu_req_valid = 1'b1;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b10 || mem_req_valid !== 1'b1) begin
      errors++; $display("FAIL abort_issue: grant=%b valid=%b want 10 1", grant, mem_req_valid);
    end
    lsu_req_valid = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", mem_req_valid); end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL abort_idle: grant=%b want 00", grant); end
    // Abort does not count as a completed transaction for tie-breaking.
    ifu_addr = $urandom;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    begin
      bit w;
      w = model_winner(1'b1, 1'b1);
      serve(w, 0, 0, 0);
      serve(!w, 0, 0, 0);
    end
    // Reset while a response is pending.
    ifu_addr = 32'h8000_4000;
    ifu_req_valid = 1'b1;
    mem_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b0;
    rstn = 1'b0;
    mem_resp_valid = 1'b1;
    ifu_resp_ready = 1'b1;
    #1;
    checks++; if (mem_resp_ready !== 1'b0 || ifu_resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_drop: mem_resp_ready=%b resp_valid=%b want 0 0", mem_resp_ready, ifu_resp_valid);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++; if (grant !== 2'b00 || mem_resp_ready !== 1'b0 || ifu_resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_resp_idle: grant=%b mem_resp_ready=%b resp_valid=%b want 00 0 0",
                          grant, mem_resp_ready, ifu_resp_valid);
    end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b00 || mem_resp_ready !== 1'b0) begin
      errors++; $display("FAIL late_resp_ignored: grant=%b mem_resp_ready=%b want 00 0", grant, mem_resp_ready);
    end
    mem_resp_valid = 1'b0;
    ifu_resp_ready = 1'b0;
    model_last = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      bit w;
      ifu_addr = $urandom;
      lsu_addr = $urandom;
      lsu_wen = $urandom_range(0, 1);
      lsu_wdata = $urandom;
      lsu_wmask = 4'($urandom);
      ifu_req_valid = 1'b1;
      lsu_req_valid = 1'b1;
      w = model_winner(1'b1, 1'b1);
`ifdef YSYX_23060184_ARB_RR_EN
      checks++; if (w !== ((k % 2) == 0)) begin errors++; $display("FAIL rr_order_model: k=%0d got %b", k, w); end
`endif
      serve(w, $urandom_range(0, 1), 0, 0);
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int  p;
      bit  i_req, l_req, w;
      p = $urandom_range(1, 3);
      i_req = p[0];
      l_req = p[1];
      ifu_addr = $urandom;
      lsu_addr = $urandom;
      lsu_wen = $urandom_range(0, 1);
      lsu_wdata = $urandom;
      lsu_wmask = 4'($urandom);
      ifu_req_valid = i_req;
      lsu_req_valid = l_req;
      w = model_winner(i_req, l_req);
      serve(w, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
      if (i_req && l_req) serve(!w, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single_ifu();
    test_collision();
    test_backpressure();
    test_abort_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
